// File: rtl/mvm_controller.sv
// Sequencing FSM for the 3x3 matrix-vector multiplier DataPath: loads x/a memories,
// runs one clear/MAC/drain/write-back pass per row into y, then streams y out.
module mvm_controller #(
    parameter int unsigned N       = 3,
    parameter int unsigned AX_W    = 4,
    parameter int unsigned AV_W    = 2,
    parameter int unsigned ACC_LAT = 4,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            reuse_matrix,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [AX_W-1:0] addr_x,
    output logic            wr_en_x,
    output logic [AV_W-1:0] addr_a,
    output logic            wr_en_a,
    output logic [AV_W-1:0] addr_y,
    output logic            wr_en_y,
    output logic            clear_acc
);

    localparam int unsigned MAX_LAT = (ACC_LAT > RD_LAT) ? ACC_LAT : RD_LAT;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [AX_W-1:0]  LAST_X     = AX_W'(N * N - 1);
    localparam logic [AX_W-1:0]  LAST_K     = AX_W'(N - 1);
    localparam logic [AX_W-1:0]  ROW_STEP   = AX_W'(N);
    localparam logic [AV_W-1:0]  LAST_C     = AV_W'(N - 1);
    localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'(ACC_LAT - 2);
    localparam logic [LAT_W-1:0] RD_LAST    = LAT_W'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD_X  = 4'd1,
        LOAD_A  = 4'd2,
        CLR     = 4'd3,
        MAC     = 4'd4,
        DRAIN   = 4'd5,
        WRY     = 4'd6,
        RD_ADDR = 4'd7,
        RD_OUT  = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic [AX_W-1:0]  k_q, k_d;
    logic [AV_W-1:0]  c_q, c_d;
    logic [AV_W-1:0]  r_q, r_d;
    logic [AX_W-1:0]  rbase_q, rbase_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic [AX_W-1:0] addr_x_q, addr_x_d;
    logic [AV_W-1:0] addr_a_q, addr_a_d;
    logic [AV_W-1:0] addr_y_q, addr_y_d;
    logic            wr_en_y_q, wr_en_y_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            clear_acc_q, clear_acc_d;

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        r_d     = r_q;
        rbase_d = rbase_q;
        lat_d   = lat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = reuse_matrix ? LOAD_A : LOAD_X;
                    k_d     = '0;
                end
            end
            LOAD_X: begin
                if (in_valid) begin
                    if (k_q == LAST_X) begin
                        state_d = LOAD_A;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + AX_W'(1);
                    end
                end
            end
            LOAD_A: begin
                if (in_valid) begin
                    if (k_q == LAST_K) begin
                        state_d = CLR;
                        k_d     = '0;
                        r_d     = '0;
                        rbase_d = '0;
                    end else begin
                        k_d = k_q + AX_W'(1);
                    end
                end
            end
            CLR: begin
                state_d = MAC;
                c_d     = '0;
            end
            MAC: begin
                if (c_q == LAST_C) begin
                    state_d = (ACC_LAT > 1) ? DRAIN : WRY;
                    lat_d   = '0;
                end else begin
                    c_d = c_q + AV_W'(1);
                end
            end
            DRAIN: begin
                if (lat_q == DRAIN_LAST) begin
                    state_d = WRY;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            WRY: begin
                if (r_q == LAST_C) begin
                    state_d = RD_ADDR;
                    k_d     = '0;
                    lat_d   = '0;
                end else begin
                    state_d = CLR;
                    r_d     = r_q + AV_W'(1);
                    rbase_d = rbase_q + ROW_STEP;
                end
            end
            RD_ADDR: begin
                if (lat_q == RD_LAST) begin
                    state_d = RD_OUT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RD_OUT: begin
                if (out_ready) begin
                    if (k_q == LAST_K) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ADDR;
                        k_d     = k_q + AX_W'(1);
                        lat_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the upcoming state so they align with it
    always_comb begin
        addr_x_d    = addr_x_q;
        addr_a_d    = addr_a_q;
        addr_y_d    = addr_y_q;
        busy_d      = (state_d != IDLE);
        clear_acc_d = (state_d == IDLE) || (state_d == CLR);
        in_ready_d  = (state_d == LOAD_X) || (state_d == LOAD_A);
        wr_en_y_d   = (state_d == WRY);
        out_valid_d = (state_d == RD_OUT);
        out_last_d  = (state_d == RD_OUT) && (k_d == LAST_K);
        done_d      = (state_d == DONE);

        case (state_d)
            LOAD_X:  addr_x_d = k_d;
            LOAD_A:  addr_a_d = AV_W'(k_d);
            MAC: begin
                addr_x_d = rbase_d + AX_W'(c_d);
                addr_a_d = c_d;
            end
            WRY:     addr_y_d = r_d;
            RD_ADDR: addr_y_d = AV_W'(k_d);
            RD_OUT:  addr_y_d = AV_W'(k_d);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            rbase_q     <= '0;
            lat_q       <= '0;
            addr_x_q    <= '0;
            addr_a_q    <= '0;
            addr_y_q    <= '0;
            wr_en_y_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            clear_acc_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            c_q         <= c_d;
            r_q         <= r_d;
            rbase_q     <= rbase_d;
            lat_q       <= lat_d;
            addr_x_q    <= addr_x_d;
            addr_a_q    <= addr_a_d;
            addr_y_q    <= addr_y_d;
            wr_en_y_q   <= wr_en_y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            clear_acc_q <= clear_acc_d;
        end
    end

    // Load strobes follow in_valid directly so each accepted element is written the same cycle
    assign wr_en_x   = (state_q == LOAD_X) && in_valid;
    assign wr_en_a   = (state_q == LOAD_A) && in_valid;

    assign addr_x    = addr_x_q;
    assign addr_a    = addr_a_q;
    assign addr_y    = addr_y_q;
    assign wr_en_y   = wr_en_y_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign clear_acc = clear_acc_q;

endmodule

// File: doc/mvm_controller.md
Name: mvm_controller

Overview:
- Sequencing FSM for the 3x3 matrix-vector multiplier DataPath.
- Accepts a streamed matrix and vector on a valid/ready handshake and drives the DataPath write strobes and addresses to load the x (matrix) and a (vector) memories.
- Sequences one clear/MAC/drain/write-back pass per row into the y memory, then streams the y results out under a valid/ready handshake.
- Carries no data: the source drives DataPath data_in directly; out_valid qualifies DataPath data_out.

Parameters:
N, 3, matrix dimension (N x N matrix, N-entry vectors)
AX_W, 4, addr_x width; N*N <= 2**AX_W
AV_W, 2, addr_a/addr_y width; N <= 2**AV_W
ACC_LAT, 4, cycles from presenting the last (addr_x, addr_a) pair of a row to the cycle where f holds the full dot product (>=1)
RD_LAT, 1, cycles from addr_y presented to data_out valid (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
reuse_matrix  in  1  sampled with start; 1 = skip matrix load and reuse stored x
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the job completes
in_valid  in  1  data_in carries a valid element
in_ready  out  1  controller accepts an element this cycle
out_valid  out  1  DataPath data_out holds y[addr_y]
out_ready  in  1  consumer accepts the current result
out_last  out  1  with out_valid, marks y[N-1]
addr_x  out  AX_W  DataPath x address
wr_en_x  out  1  x write strobe
addr_a  out  AV_W  DataPath a address
wr_en_a  out  1  a write strobe
addr_y  out  AV_W  DataPath y address
wr_en_y  out  1  y write strobe
clear_acc  out  1  accumulator clear

Behaviour:
- States: IDLE, LOAD_X, LOAD_A, CLR, MAC, DRAIN, WRY, RD_ADDR, RD_OUT, DONE.
- Reset (asynchronous, immediate): state IDLE; all addresses 0; wr_en_x, wr_en_a, wr_en_y, in_ready, out_valid, out_last, done, busy are 0; clear_acc is 1.
  - Reset mid-operation aborts the job; stored memory contents are not guaranteed.
- IDLE:
  - clear_acc = 1.
  - start=1 -> LOAD_X, or LOAD_A if reuse_matrix=1.
  - start in any other state is ignored.
- LOAD_X:
  - in_ready = 1.
  - wr_en_x = in_valid (combinational); addr_x = element counter k, row-major, k = r*N + c.
  - k increments only on an accepted element; bubbles produce no write.
  - After accepting element N*N-1 -> LOAD_A, k reset to 0.
- LOAD_A:
  - Same handshake with wr_en_a and addr_a = k.
  - After accepting element N-1 -> CLR with row r = 0.
- in_valid outside the load states is ignored; in_ready is 0 there.
- CLR (1 cycle): clear_acc = 1.
- MAC (N cycles): column c = 0..N-1; addr_x = r*N + c, addr_a = c.
- DRAIN (ACC_LAT-1 cycles, skipped if ACC_LAT = 1): addresses hold their last values.
- WRY (1 cycle):
  - wr_en_y = 1, addr_y = r.
  - r < N-1 -> r+1, back to CLR; otherwise -> RD_ADDR with k = 0.
  - Each row therefore takes N+ACC_LAT+1 cycles; clear_acc never overlaps an in-flight product.
- RD_ADDR (RD_LAT cycles): addr_y = k; out_valid = 0.
- RD_OUT:
  - out_valid = 1; out_last = (k == N-1); addr_y held.
  - On out_ready: k++ -> RD_ADDR, or -> DONE after the last element.
  - With out_ready = 0, all outputs are held stable indefinitely.
- DONE (1 cycle): done = 1, then -> IDLE.
- Address outputs are registered and hold their value when unused. wr_en_x and wr_en_a are the only combinational paths (in_valid to strobe).
- Arithmetic: row base r*N is kept as a running counter; no multiplier.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> clear_acc=1, all strobes, in_ready, out_valid, busy and done are 0, addresses 0. Assert reset_n=0 asynchronously mid-MAC -> the same values appear before the next clk edge.
- Full job, controller plus DataPath, defaults:
  - Stimulus: start at cycle 0; matrix 1..9 and vector 1,2,3 streamed with in_valid held high; out_ready=1.
  - wr_en_x in cycles 1-9 with addr_x 0..8; wr_en_a in cycles 10-12 with addr_a 0..2.
  - wr_en_y in cycles 20, 28, 36.
  - Outputs 14, 32, 50 with out_last on 50; done in cycle 43.
- Input bubbles: in_valid toggled 1,0,0,1,... -> writes occur only on valid cycles, with contiguous addresses; results are unchanged at 14, 32, 50.
- Reuse: second job with reuse_matrix=1 and vector 1,0,0 -> no wr_en_x pulses; outputs 1, 4, 7.
- Backpressure: out_ready=0 for 5 cycles at each result -> out_valid, addr_y and data_out stay stable; done is delayed by exactly 15 cycles.
- Start while busy: pulse start during MAC -> no effect on sequence or results; busy stays 1 until done.
